// File: rtl/rf_pkg.sv
// Shared constants and dump-sequencer state encoding for the rf_param register file.
package rf_pkg;

  localparam int unsigned RF_DATA_W = 16;
  localparam int unsigned RF_ADDR_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DUMP = 2'd1,
    ST_DONE = 2'd2
  } rf_state_e;

endpackage

// File: rtl/rf_dump_ctrl.sv
// Register-dump sequencer: detects a rising edge on hlt, then walks every index once
// and signals completion until hlt is released.
module rf_dump_ctrl
  import rf_pkg::*;
#(
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hlt,
  output logic              busy,
  output logic              dump_valid,
  output logic              dump_done,
  output logic [ADDR_W-1:0] dump_idx
);

  localparam logic [ADDR_W-1:0] LAST_IDX = '1;

  rf_state_e         state;
  rf_state_e         state_d;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idx_d;
  logic              hlt_q;
  logic              hlt_rise;

  assign hlt_rise = hlt & ~hlt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      idx   <= '0;
      hlt_q <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      hlt_q <= hlt;
    end
  end

  // Outputs decode from state only, so they fall to zero as soon as rst asserts.
  always_comb begin
    state_d    = state;
    idx_d      = idx;
    busy       = 1'b0;
    dump_valid = 1'b0;
    dump_done  = 1'b0;
    dump_idx   = '0;
    unique case (state)
      ST_IDLE: begin
        if (hlt_rise) begin
          state_d = ST_DUMP;
          idx_d   = '0;
        end
      end
      ST_DUMP: begin
        busy       = 1'b1;
        dump_valid = 1'b1;
        dump_idx   = idx;
        if (idx == LAST_IDX) begin
          state_d = ST_DONE;
          idx_d   = '0;
        end else begin
          idx_d = idx + ADDR_W'(1);
        end
      end
      ST_DONE: begin
        dump_done = 1'b1;
        if (!hlt) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

endmodule

// File: rtl/rf_param.sv
// Parameterised 2-read/1-write register file with r0 hardwired to zero and a halt-triggered dump.
// Define RF_BYPASS_EN to forward same-cycle write data onto matching read ports.
module rf_param
  import rf_pkg::*;
#(
  parameter int unsigned DATA_W = RF_DATA_W,
  parameter int unsigned ADDR_W = RF_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  input  logic [ADDR_W-1:0] rd,
  input  logic              we,
  input  logic [DATA_W-1:0] write_data,
  output logic [DATA_W-1:0] out_rs,
  output logic [DATA_W-1:0] out_rt,
  input  logic              hlt,
  output logic              busy,
  output logic              dump_valid,
  output logic [ADDR_W-1:0] dump_idx,
  output logic [DATA_W-1:0] dump_data,
  output logic              dump_done
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs [DEPTH];
  logic              wr_en;

  assign wr_en = we && (rd != '0) && !busy;

  rf_dump_ctrl #(
    .ADDR_W (ADDR_W)
  ) u_dump_ctrl (
    .clk        (clk),
    .rst        (rst),
    .hlt        (hlt),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_done  (dump_done),
    .dump_idx   (dump_idx)
  );

  // Index 0 is never written, so it holds its reset value of zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(DEPTH); i++) regs[i] <= '0;
    end else if (wr_en) begin
      regs[rd] <= write_data;
    end
  end

`ifdef RF_BYPASS_EN
  assign out_rs = (wr_en && (rd == rs)) ? write_data : regs[rs];
  assign out_rt = (wr_en && (rd == rt)) ? write_data : regs[rt];
`else
  assign out_rs = regs[rs];
  assign out_rt = regs[rt];
`endif

  assign dump_data = dump_valid ? regs[dump_idx] : '0;

endmodule

// File: tb/tb_rf_param.sv
// Self-checking bench for rf_param: directed scenarios plus random traffic against a
// behavioural model (array of register values and a dump beat counter).
module tb_rf_param;
  import rf_pkg::*;

  localparam int unsigned DW    = RF_DATA_W;
  localparam int unsigned AW    = RF_ADDR_W;
  localparam int unsigned DEPTH = 1 << AW;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] rs, rt, rd;
  logic          we;
  logic [DW-1:0] write_data;
  logic [DW-1:0] out_rs, out_rt;
  logic          hlt;
  logic          busy, dump_valid, dump_done;
  logic [AW-1:0] dump_idx;
  logic [DW-1:0] dump_data;

  rf_param #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .rs         (rs),
    .rt         (rt),
    .rd         (rd),
    .we         (we),
    .write_data (write_data),
    .out_rs     (out_rs),
    .out_rt     (out_rt),
    .hlt        (hlt),
    .busy       (busy),
    .dump_valid (dump_valid),
    .dump_idx   (dump_idx),
    .dump_data  (dump_data),
    .dump_done  (dump_done)
  );

  always #5 clk = ~clk;

  // Reference model: register contents, current dump beat (-1 = not dumping), done flag.
  logic [DW-1:0] mdl_mem [DEPTH];
  int            mdl_beat;
  bit            mdl_done;
  bit            mdl_hlt_prev;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) mdl_mem[i] = '0;
    mdl_beat     = -1;
    mdl_done     = 1'b0;
    mdl_hlt_prev = 1'b0;
  endtask

  task automatic model_check();
    logic [DW-1:0] e_rs, e_rt;
    bit            dumping;
    dumping = (mdl_beat >= 0);
    e_rs = mdl_mem[rs];
    e_rt = mdl_mem[rt];
`ifdef RF_BYPASS_EN
    if (we && rd != 0 && !dumping && rd == rs) e_rs = write_data;
    if (we && rd != 0 && !dumping && rd == rt) e_rt = write_data;
`endif
    check("out_rs", 32'(out_rs), 32'(e_rs));
    check("out_rt", 32'(out_rt), 32'(e_rt));
    check("busy", 32'(busy), 32'(dumping));
    check("dump_valid", 32'(dump_valid), 32'(dumping));
    check("dump_done", 32'(dump_done), 32'(mdl_done));
    check("dump_idx", 32'(dump_idx), dumping ? 32'(mdl_beat) : 32'd0);
    check("dump_data", 32'(dump_data), dumping ? 32'(mdl_mem[mdl_beat]) : 32'd0);
  endtask

  // Drive one cycle's inputs at the falling edge, then compare outputs against the model.
  task automatic apply(input logic r, input logic h, input logic w, input logic [AW-1:0] d,
                       input logic [DW-1:0] wd, input logic [AW-1:0] s, input logic [AW-1:0] t);
    @(negedge clk);
    rst = r; hlt = h; we = w; rd = d; write_data = wd; rs = s; rt = t;
    #1;
    if (rst) model_reset();
    model_check();
  endtask

  // Advance the model across the rising edge using the inputs currently applied.
  task automatic tick();
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (we && rd != 0 && mdl_beat < 0) mdl_mem[rd] = write_data;
      if (mdl_beat >= 0) begin
        if (mdl_beat == int'(DEPTH) - 1) begin
          mdl_beat = -1;
          mdl_done = 1'b1;
        end else begin
          mdl_beat++;
        end
      end else if (mdl_done) begin
        if (!hlt) mdl_done = 1'b0;
      end else if (hlt && !mdl_hlt_prev) begin
        mdl_beat = 0;
      end
      mdl_hlt_prev = hlt;
    end
  endtask

  task automatic step(input logic r, input logic h, input logic w, input logic [AW-1:0] d,
                      input logic [DW-1:0] wd, input logic [AW-1:0] s, input logic [AW-1:0] t);
    apply(r, h, w, d, wd, s, t);
    tick();
  endtask

  initial begin
    logic h_r;
    model_reset();
    rst = 1'b1; hlt = 1'b0; we = 1'b0; rd = '0; write_data = '0; rs = '0; rt = '0;

    // Reset state
    apply(1'b1, 1'b0, 1'b1, AW'(4), DW'(16'h7777), AW'(4), AW'(0));
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_rs", 32'(out_rs), 32'd0);
    tick();
    step(1'b1, 1'b0, 1'b0, '0, '0, '0, '0);

    // Write then read
    step(1'b0, 1'b0, 1'b1, AW'(3), DW'(16'hBEEF), AW'(0), AW'(0));
    apply(1'b0, 1'b0, 1'b0, '0, '0, AW'(3), AW'(3));
    check("wr_rd_r3", 32'(out_rs), 32'h0000BEEF);
    tick();

    // r0 stays zero
    step(1'b0, 1'b0, 1'b1, AW'(0), DW'(16'h1234), AW'(0), AW'(0));
    apply(1'b0, 1'b0, 1'b0, '0, '0, AW'(0), AW'(3));
    check("r0_zero", 32'(out_rs), 32'd0);
    tick();

    // Same-cycle read of a register being written
    step(1'b0, 1'b0, 1'b1, AW'(5), DW'(16'h1111), AW'(0), AW'(0));
    apply(1'b0, 1'b0, 1'b1, AW'(5), DW'(16'hA5A5), AW'(5), AW'(5));
`ifdef RF_BYPASS_EN
    check("bypass_rs", 32'(out_rs), 32'h0000A5A5);
`else
    check("nobypass_rs", 32'(out_rs), 32'h00001111);
`endif
    tick();
    apply(1'b0, 1'b0, 1'b0, '0, '0, AW'(5), AW'(0));
    check("post_wr_r5", 32'(out_rs), 32'h0000A5A5);
    tick();

    // Full dump with writes to r2 attempted throughout
    for (int i = 1; i < int'(DEPTH); i++)
      step(1'b0, 1'b0, 1'b1, AW'(i), DW'(i * 32'h0101), AW'(i), AW'(0));
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < int'(DEPTH); i++) begin
      apply(1'b0, 1'b1, 1'b1, AW'(2), DW'(16'hFFFF), AW'(2), AW'(i));
      check("dump_beat_valid", 32'(dump_valid), 32'd1);
      check("dump_beat_idx", 32'(dump_idx), 32'(i));
      check("dump_beat_data", 32'(dump_data), 32'(DW'(i * 32'h0101)));
      tick();
    end
    apply(1'b0, 1'b1, 1'b0, '0, '0, AW'(2), '0);
    check("dump_done_hi", 32'(dump_done), 32'd1);
    check("dump_done_valid", 32'(dump_valid), 32'd0);
    check("r2_unchanged", 32'(out_rs), 32'h00000202);
    tick();
    step(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    apply(1'b0, 1'b0, 1'b0, '0, '0, '0, '0);
    check("back_idle_done", 32'(dump_done), 32'd0);
    tick();

    // Reset during beat 7
    step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, 1'b0, '0, '0, '0, '0);
    apply(1'b0, 1'b1, 1'b0, '0, '0, AW'(7), '0);
    check("pre_rst_idx", 32'(dump_idx), 32'd7);
    rst = 1'b1;
    hlt = 1'b0;
    #1;
    model_reset();
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_valid", 32'(dump_valid), 32'd0);
    check("midrst_r7", 32'(out_rs), 32'd0);
    tick();
    for (int i = 0; i < int'(DEPTH); i++) begin
      apply(1'b0, 1'b0, 1'b0, '0, '0, AW'(i), AW'(int'(DEPTH) - 1 - i));
      check("post_rst_reg", 32'(out_rs), 32'd0);
      tick();
    end

    // Random traffic
    h_r = 1'b0;
    for (int n = 0; n < 1500; n++) begin
      if ($urandom_range(0, 9) == 0) h_r = ~h_r;
      step(($urandom_range(0, 299) == 0), h_r, 1'($urandom), AW'($urandom), DW'($urandom),
           AW'($urandom), AW'($urandom));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rf_param.md
RF_PARAM -- requirements
Module: rf_param

Interface
REQ-001 SHALL have parameter DATA_W, default 16: register width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4: register index width; DEPTH = 2**ADDR_W registers.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on posedge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have ports rs, rt  input  ADDR_W each  read-port indices.
REQ-006 SHALL have port rd  input  ADDR_W  write index.
REQ-007 SHALL have port we  input  1  write enable.
REQ-008 SHALL have port write_data  input  DATA_W  write value.
REQ-009 SHALL have ports out_rs, out_rt  output  DATA_W each  read data.
REQ-010 SHALL have port hlt  input  1  halt request; rising edge starts a register dump.
REQ-011 SHALL have port busy  output  1  high while a dump is in progress.
REQ-012 SHALL have ports dump_valid (1), dump_idx (ADDR_W), dump_data (DATA_W)  outputs  dump stream.
REQ-013 SHALL have port dump_done  output  1  dump complete.

Function
REQ-014 SHALL read combinationally: out_rs = regs[rs], out_rt = regs[rt], with zero cycles of latency.
REQ-015 SHALL write regs[rd] <= write_data on posedge clk when we=1, rd!=0 and busy=0.
REQ-016 SHALL hardwire regs[0] to 0; writes to index 0 are discarded, and reads of index 0 return 0.
REQ-017 SHALL detect a hlt rising edge using a registered copy hlt_q; edge = hlt & ~hlt_q.
REQ-018 SHALL implement FSM IDLE -> DUMP on the edge; DUMP -> DONE after emitting index DEPTH-1; DONE -> IDLE when hlt=0.
REQ-019 SHALL, in DUMP, emit one register per cycle starting at index 0: dump_valid=1, dump_idx=idx, dump_data=regs[idx]; idx increments by 1 each cycle.
REQ-020 SHALL hold busy=1 in DUMP only; writes are ignored while busy=1, and reads stay functional.
REQ-021 SHALL hold dump_done=1 in DONE only; dump_valid=0 outside DUMP.
REQ-022 SHALL ignore a hlt edge occurring in DUMP or DONE; a new dump requires a return to IDLE first.
REQ-023 SHALL take exactly DEPTH cycles for a dump; idx does not wrap past DEPTH-1.

Reset
REQ-024 SHALL, on rst, clear all registers to 0 and return to IDLE with idx=0 and hlt_q=0.
REQ-025 SHALL, while rst is asserted, drive busy=0, dump_valid=0, dump_done=0, dump_idx=0 and dump_data=0.
REQ-026 SHALL abort a dump on rst mid-dump; no further dump beats are emitted, and a new hlt edge is needed after reset releases.

Configuration
REQ-027 SHALL, with RF_BYPASS_EN defined, forward write_data to out_rs/out_rt in the same cycle when we=1, busy=0, rd!=0 and rd equals that read index.
REQ-028 SHALL, without RF_BYPASS_EN, return the pre-write value until after the posedge; no forwarding logic is built.

Structure
REQ-029 SHALL place the FSM state encoding (IDLE, DUMP, DONE) and the default DATA_W/ADDR_W constants in shared package rf_pkg.
REQ-030 SHALL implement the dump sequencer as sub-module rf_dump_ctrl, which owns the FSM, idx and the edge detect; the register array remains in rf_param.

Verification
REQ-031 SHALL cover write/read: write 16'hBEEF to r3, then read rs=3 -> out_rs=16'hBEEF on the next cycle.
REQ-032 SHALL cover r0: write 16'h1234 to r0 -> out_rs=0 when rs=0.
REQ-033 SHALL cover bypass: we=1, rd=rs=5, write_data=16'hA5A5 -> with RF_BYPASS_EN, out_rs=16'hA5A5 in the same cycle; without it, the old value.
REQ-034 SHALL cover dump: load r1..r15 with i*16'h0101, then pulse hlt -> 16 beats with idx 0..15 and data 0, 0101, ..., 0F0F, followed by dump_done=1.
REQ-035 SHALL cover write-during-dump: we=1 to r2 with busy=1 -> r2 unchanged after the dump.
REQ-036 SHALL cover reset mid-dump: assert rst at beat 7 -> busy=0, dump_valid=0, all registers read 0.
